// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared definitions for the VGA raster timing block:
//   - default 640x480@60 timing constants (pixels / lines)
//   - sync polarity constants
//   - timing_total(): sums active + porches + sync into a line/frame total
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Total period of one axis (pixels per line or lines per frame).
  function automatic int timing_total(input int active, input int front,
                                      input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_clk_en.sv
// pixel_clk_en
//   Divides clk into a one-clk-wide enable strobe every N clocks.
//   The first strobe appears in the first clk cycle after rst is released;
//   with N = 1 the strobe is permanently high out of reset.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   pix_en out  registered pixel-rate strobe
module pixel_clk_en #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] div_cnt_reg;
  logic [CW-1:0] div_cnt_next;

  always_comb begin
    div_cnt_next = (div_cnt_reg == LAST) ? '0 : div_cnt_reg + CW'(1);
  end

  // Counter parks on LAST during reset so the very first edge after
  // release rolls it to zero and raises the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= LAST;
      pix_en      <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      pix_en      <= (div_cnt_next == '0);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator: pixel strobe, hsync/vsync, display_on,
//   active-area x/y, line/frame start pulses and a frame counter.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   pix_en       out  one-clk strobe at pixel rate
//   hsync        out  horizontal sync, active level hsync_pol
//   vsync        out  vertical sync, active level vsync_pol
//   display_on   out  presented position lies in the active area
//   x, y         out  active-area coordinates, 0 while blanking
//   line_start   out  one-clk pulse when column 0 is first presented
//   frame_start  out  one-clk pulse when (0,0) is first presented
//   frame_cnt    out  index of the current frame (wraps)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   clk_mhz   = 50,
  parameter int   pixel_mhz = 25,
  parameter int   h_active  = H_ACTIVE,
  parameter int   h_front   = H_FRONT,
  parameter int   h_sync    = H_SYNC,
  parameter int   h_back    = H_BACK,
  parameter int   v_active  = V_ACTIVE,
  parameter int   v_front   = V_FRONT,
  parameter int   v_sync    = V_SYNC,
  parameter int   v_back    = V_BACK,
  parameter logic hsync_pol = SYNC_ACTIVE_LOW,
  parameter logic vsync_pol = SYNC_ACTIVE_LOW,
  parameter int   w_x       = $clog2(h_active),
  parameter int   w_y       = $clog2(v_active),
  parameter int   w_frame   = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [w_x-1:0]     x,
  output logic [w_y-1:0]     y,
  output logic               line_start,
  output logic               frame_start,
  output logic [w_frame-1:0] frame_cnt
);

  localparam int N       = clk_mhz / pixel_mhz;
  localparam int H_TOTAL = timing_total(h_active, h_front, h_sync, h_back);
  localparam int V_TOTAL = timing_total(v_active, v_front, v_sync, v_back);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // All decode thresholds live at counter width so that x/y truncation
  // never affects the comparisons.
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(h_active);
  localparam logic [HW-1:0] HS_START   = HW'(h_active + h_front);
  localparam logic [HW-1:0] HS_END     = HW'(h_active + h_front + h_sync);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(v_active);
  localparam logic [VW-1:0] VS_START   = VW'(v_active + v_front);
  localparam logic [VW-1:0] VS_END     = VW'(v_active + v_front + v_sync);

  generate
    if (clk_mhz % pixel_mhz != 0) begin : g_bad_ratio
      $error("vga_timing_gen: clk_mhz must be an integer multiple of pixel_mhz");
    end
  endgenerate

  pixel_clk_en #(
    .N (N)
  ) u_pixel_clk_en (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  logic [HW-1:0] h_cnt_reg, h_next;
  logic [VW-1:0] v_cnt_reg, v_next;
  logic          de_next, hs_act, vs_act, line_next, frame_next;

  always_comb begin
    h_next = h_cnt_reg;
    v_next = v_cnt_reg;
    if (pix_en) begin
      if (h_cnt_reg == H_LAST) begin
        h_next = '0;
        v_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + VW'(1);
      end else begin
        h_next = h_cnt_reg + HW'(1);
      end
    end
  end

  // Decode from the next position so every registered output describes
  // the same pixel as the counters after this edge.
  always_comb begin
    de_next    = (h_next < H_ACT_END) && (v_next < V_ACT_END);
    hs_act     = (h_next >= HS_START) && (h_next < HS_END);
    vs_act     = (v_next >= VS_START) && (v_next < VS_END);
    // Qualifying with pix_en limits the pulse to the first clk of the pixel.
    line_next  = pix_en && (h_next == '0);
    frame_next = line_next && (v_next == '0);
  end

  // Counters rest at the last position of the frame so the first advance
  // after release presents (0,0) together with frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_reg   <= H_LAST;
      v_cnt_reg   <= V_LAST;
      hsync       <= ~hsync_pol;
      vsync       <= ~vsync_pol;
      display_on  <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '1;
    end else begin
      h_cnt_reg   <= h_next;
      v_cnt_reg   <= v_next;
      hsync       <= hs_act ? hsync_pol : ~hsync_pol;
      vsync       <= vs_act ? vsync_pol : ~vsync_pol;
      display_on  <= de_next;
      x           <= de_next ? w_x'(h_next) : '0;
      y           <= de_next ? w_y'(v_next) : '0;
      line_start  <= line_next;
      frame_start <= frame_next;
      if (frame_next) begin
        frame_cnt <= frame_cnt + w_frame'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Two instances with small timings: A (N=2, active-low syncs, 16-bit
//   frame counter) and B (N=1, active-high syncs, 3-bit frame counter).
//   Outputs are checked every cycle against an arithmetic model driven by
//   the number of clock edges since reset release, plus a vector table
//   of hand-derived boundary points and hand-written reset sequences.
module tb_vga_timing_gen;

  // Instance A geometry: 25 x 14, N = 2 -> 700 clk per frame
  localparam int A_HA = 16, A_HF = 2, A_HS = 4, A_HB = 3;
  localparam int A_VA = 8,  A_VF = 1, A_VS = 2, A_VB = 3;
  // Instance B geometry: 12 x 7, N = 1 -> 84 clk per frame
  localparam int B_HA = 8,  B_HF = 1, B_HS = 2, B_HB = 1;
  localparam int B_VA = 4,  B_VF = 1, B_VS = 1, B_VB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_pix, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [3:0]  a_x;
  logic [2:0]  a_y;
  logic [15:0] a_fc;
  logic        b_pix, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [2:0]  b_x;
  logic [1:0]  b_y;
  logic [2:0]  b_fc;

  vga_timing_gen #(
    .clk_mhz(50), .pixel_mhz(25),
    .h_active(A_HA), .h_front(A_HF), .h_sync(A_HS), .h_back(A_HB),
    .v_active(A_VA), .v_front(A_VF), .v_sync(A_VS), .v_back(A_VB),
    .hsync_pol(1'b0), .vsync_pol(1'b0), .w_frame(16)
  ) dut_a (
    .clk(clk), .rst(rst), .pix_en(a_pix), .hsync(a_hs), .vsync(a_vs),
    .display_on(a_de), .x(a_x), .y(a_y), .line_start(a_ls),
    .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .clk_mhz(50), .pixel_mhz(50),
    .h_active(B_HA), .h_front(B_HF), .h_sync(B_HS), .h_back(B_HB),
    .v_active(B_VA), .v_front(B_VF), .v_sync(B_VS), .v_back(B_VB),
    .hsync_pol(1'b1), .vsync_pol(1'b1), .w_frame(3)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(b_pix), .hsync(b_hs), .vsync(b_vs),
    .display_on(b_de), .x(b_x), .y(b_y), .line_start(b_ls),
    .frame_start(b_fs), .frame_cnt(b_fc)
  );

  typedef struct {
    int pix, hs, vs, de, x, y, ls, fs, fc;
  } exp_t;

  typedef struct {
    int t;
    int is_b;
    int pix, hs, vs, de, x, y, ls, fs, fc;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int t;          // clock edges since reset release
  bit chk_on = 0;

  always @(posedge clk) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", name, t, act, exp_v);
    end
  endtask

  // Position follows directly from elapsed clocks: pixel q is presented
  // from edge 2+N*q, the strobe rises on edges 1, 1+N, 1+2N, ...
  function automatic exp_t model(input int tt, input int n,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input int hp, input int vp, input int wf);
    exp_t e;
    int ht, vt, q, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    e.pix = (tt >= 1 && (tt - 1) % n == 0) ? 1 : 0;
    if (tt < 2) begin
      e.hs = 1 - hp; e.vs = 1 - vp; e.de = 0; e.x = 0; e.y = 0;
      e.ls = 0; e.fs = 0; e.fc = (1 << wf) - 1;
      return e;
    end
    q = (tt - 2) / n;
    h = q % ht;
    v = (q / ht) % vt;
    e.de = (h < ha && v < va) ? 1 : 0;
    e.x  = e.de ? h : 0;
    e.y  = e.de ? v : 0;
    e.ls = ((tt - 2) % n == 0 && h == 0) ? 1 : 0;
    e.fs = (e.ls == 1 && v == 0) ? 1 : 0;
    e.hs = (h >= ha + hf && h < ha + hf + hs) ? hp : 1 - hp;
    e.vs = (v >= va + vf && v < va + vf + vs) ? vp : 1 - vp;
    e.fc = (q / (ht * vt)) % (1 << wf);
    return e;
  endfunction

  function automatic exp_t model_a(input int tt);
    return model(tt, 2, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 0, 0, 16);
  endfunction

  function automatic exp_t model_b(input int tt);
    return model(tt, 1, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1, 1, 3);
  endfunction

  task automatic check_dut(input string tag, input int is_b, input exp_t e);
    if (is_b != 0) begin
      chk({tag, "B.pix_en"},      int'(b_pix), e.pix);
      chk({tag, "B.hsync"},       int'(b_hs),  e.hs);
      chk({tag, "B.vsync"},       int'(b_vs),  e.vs);
      chk({tag, "B.display_on"},  int'(b_de),  e.de);
      chk({tag, "B.x"},           int'(b_x),   e.x);
      chk({tag, "B.y"},           int'(b_y),   e.y);
      chk({tag, "B.line_start"},  int'(b_ls),  e.ls);
      chk({tag, "B.frame_start"}, int'(b_fs),  e.fs);
      chk({tag, "B.frame_cnt"},   int'(b_fc),  e.fc);
    end else begin
      chk({tag, "A.pix_en"},      int'(a_pix), e.pix);
      chk({tag, "A.hsync"},       int'(a_hs),  e.hs);
      chk({tag, "A.vsync"},       int'(a_vs),  e.vs);
      chk({tag, "A.display_on"},  int'(a_de),  e.de);
      chk({tag, "A.x"},           int'(a_x),   e.x);
      chk({tag, "A.y"},           int'(a_y),   e.y);
      chk({tag, "A.line_start"},  int'(a_ls),  e.ls);
      chk({tag, "A.frame_start"}, int'(a_fs),  e.fs);
      chk({tag, "A.frame_cnt"},   int'(a_fc),  e.fc);
    end
  endtask

  // Continuous model comparison plus strobe period checks.
  int last_ls_a = 0, last_fs_a = 0, last_ls_b = 0, last_fs_b = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      check_dut("model.", 0, model_a(t));
      check_dut("model.", 1, model_b(t));
      if (t < 2) begin
        last_ls_a = 0; last_fs_a = 0; last_ls_b = 0; last_fs_b = 0;
      end
      if (a_ls) begin
        if (last_ls_a != 0) chk("A.line_period", t - last_ls_a, 50);
        last_ls_a = t;
      end
      if (a_fs) begin
        if (last_fs_a != 0) chk("A.frame_period", t - last_fs_a, 700);
        last_fs_a = t;
      end
      if (b_ls) begin
        if (last_ls_b != 0) chk("B.line_period", t - last_ls_b, 12);
        last_ls_b = t;
      end
      if (b_fs) begin
        if (last_fs_b != 0) chk("B.frame_period", t - last_fs_b, 84);
        last_fs_b = t;
      end
    end
  end

  // First-frame aggregates for instance A (edges 2..701 = frame 0).
  bit agg_on = 1;
  int de_clks = 0, hs_clks = 0, vs_clks = 0, ls_pulses = 0;
  always @(negedge clk) begin
    if (chk_on && agg_on && t >= 2 && t <= 701) begin
      if (a_de) de_clks <= de_clks + 1;
      if (!a_hs && t <= 51) hs_clks <= hs_clks + 1;
      if (!a_vs) vs_clks <= vs_clks + 1;
      if (a_ls) ls_pulses <= ls_pulses + 1;
    end
  end

  task automatic wait_t(input int target);
    int g = 0;
    while (t != target && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (t != target) chk("wait_timeout", t, target);
  endtask

  task automatic release_rst();
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t vecs[20];
  exp_t ev;

  initial begin
    //         t    b  pix hs vs de  x  y ls fs  fc
    vecs[0]  = '{1,   0, 1, 1, 1, 0, 0, 0, 0, 0, 65535};
    vecs[1]  = '{1,   1, 1, 0, 0, 0, 0, 0, 0, 0, 7};
    vecs[2]  = '{2,   0, 0, 1, 1, 1, 0, 0, 1, 1, 0};
    vecs[3]  = '{2,   1, 1, 0, 0, 1, 0, 0, 1, 1, 0};
    vecs[4]  = '{3,   0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    vecs[5]  = '{3,   1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[6]  = '{11,  1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{13,  1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{38,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{44,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{46,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{382, 0, 0, 1, 1, 1, 15, 7, 0, 0, 0};
    vecs[12] = '{384, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{452, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[14] = '{552, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0};
    vecs[15] = '{673, 1, 1, 0, 0, 0, 0, 0, 0, 0, 7};
    vecs[16] = '{674, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0};
    vecs[17] = '{700, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[18] = '{702, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
    vecs[19] = '{703, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state while rst is held.
    check_dut("rst.", 0, '{0, 1, 1, 0, 0, 0, 0, 0, 65535});
    check_dut("rst.", 1, '{0, 0, 0, 0, 0, 0, 0, 0, 7});
    #1 rst = 1'b0;
    chk_on = 1;

    foreach (vecs[i]) begin
      wait_t(vecs[i].t);
      ev = '{vecs[i].pix, vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].x,
             vecs[i].y, vecs[i].ls, vecs[i].fs, vecs[i].fc};
      check_dut("vec.", vecs[i].is_b, ev);
      $display("vec %0d t=%0d dut=%s de=%0d x=%0d y=%0d ls=%0d fs=%0d",
               i, vecs[i].t, vecs[i].is_b != 0 ? "B" : "A",
               vecs[i].de, vecs[i].x, vecs[i].y, vecs[i].ls, vecs[i].fs);
    end

    agg_on = 0;
    chk("A.display_on_clks", de_clks, A_HA * A_VA * 2);
    chk("A.hsync_low_clks_line0", hs_clks, A_HS * 2);
    chk("A.vsync_low_clks", vs_clks, A_VS * 25 * 2);
    chk("A.line_starts_frame0", ls_pulses, 14);
    $display("frame0 A: display_on=%0d hsync_low=%0d vsync_low=%0d line_starts=%0d",
             de_clks, hs_clks, vs_clks, ls_pulses);

    // Mid-frame reset at A position (10,5) of frame 1; outputs must drop
    // to reset values before the next clock edge.
    wait_t(2 + 2 * (350 + 5 * 25 + 10));
    chk("A.de_before_reset", int'(a_de), 1);
    #2 rst = 1'b1;
    #1;
    check_dut("async.", 0, '{0, 1, 1, 0, 0, 0, 0, 0, 65535});
    check_dut("async.", 1, '{0, 0, 0, 0, 0, 0, 0, 0, 7});
    repeat (2) @(posedge clk);
    release_rst();
    wait_t(1);
    chk("restart.A.pix_en", int'(a_pix), 1);
    wait_t(2);
    chk("restart.A.frame_start", int'(a_fs), 1);
    chk("restart.A.frame_cnt", int'(a_fc), 0);
    chk("restart.A.x", int'(a_x), 0);
    chk("restart.A.display_on", int'(a_de), 1);
    $display("mid-frame reset at A(10,5): restart fs=%0d fc=%0d", a_fs, a_fc);

    // Randomised run lengths with asynchronous resets landing between edges.
    for (int k = 0; k < 6; k++) begin
      int run_len, off;
      run_len = $urandom_range(30, 1500);
      off = $urandom_range(1, 3);
      repeat (run_len) @(negedge clk);
      #(off) rst = 1'b1;
      #1;
      check_dut("rnd_async.", 0, model_a(0));
      check_dut("rnd_async.", 1, model_b(0));
      repeat ($urandom_range(1, 3)) @(posedge clk);
      release_rst();
      $display("segment %0d: ran %0d clk, reset offset %0d", k, run_len, off);
    end
    repeat (800) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
